axiuart_frame_builder: RTL and testbench
========================================

Name: axiuart_frame_builder

Overview:
- Response-frame serializer downstream of the frame parser / command executor.
- Takes one completed transaction result (status, echoed command, address, read data) and emits a device-to-host response frame, one byte per clock, into the UART TX FIFO.
- Appends a CRC-8 computed on the fly.
- Single outstanding request; the executor holds read data in its own buffer, and this block fetches it by index.

Parameters:
- MAX_DATA_BYTES, 64: maximum data payload bytes per frame.
- SOF_DEVICE_TO_HOST, 8'h5A: start-of-frame byte.
- STALL_LIMIT, 65535: TX-FIFO-full cycles tolerated before abort (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- build_req  input  1  request to emit a response; inputs below valid while high
- build_ack  output  1  one-cycle pulse; request accepted and inputs latched
- status_code  input  8  status byte (8'h00 = OK)
- cmd_echo  input  8  command byte to echo; bit7 = 1 means read
- addr  input  32  transaction address
- data_len  input  7  number of read-data bytes, 0..MAX_DATA_BYTES
- resp_data_idx  output  6  index of data byte requested from executor buffer
- resp_data_byte  input  8  byte at resp_data_idx, valid combinationally in the same cycle
- tx_fifo_data  output  8  byte to TX FIFO
- tx_fifo_wr_en  output  1  TX FIFO write strobe
- tx_fifo_full  input  1  TX FIFO full
- build_busy  output  1  high from acceptance until frame completes
- build_done  output  1  one-cycle pulse after the CRC byte is written
- build_abort  output  1  one-cycle pulse on stall abort (optional feature; tied 0 otherwise)

Behaviour:
- Reset (rst == 0 at posedge): state IDLE, all counters and CRC = 0.
  - Outputs held at reset: build_ack, tx_fifo_wr_en, build_busy, build_done, build_abort = 0; tx_fifo_data = 8'h00; resp_data_idx = 0.
  - Reset mid-frame abandons the frame immediately: no further writes, no build_done.
- States: IDLE, SOF, STATUS, CMD, ADDR, DATA, CRC, DONE.
- IDLE:
  - If build_req, pulse build_ack in the same cycle and latch status_code, cmd_echo, addr, data_len. Saturate data_len to MAX_DATA_BYTES if it exceeds it.
  - Next state SOF. build_busy rises the following cycle.
- Emit states (SOF, STATUS, CMD, ADDR, DATA, CRC):
  - tx_fifo_wr_en = !tx_fifo_full, decoded combinationally from registered state.
  - tx_fifo_data holds the current byte.
  - The state/counter advances only on a cycle where wr_en = 1. Never write while full; never duplicate or drop a byte.
- Byte order:
  - SOF: SOF_DEVICE_TO_HOST.
  - STATUS: latched status_code.
  - CMD: latched cmd_echo.
  - ADDR / DATA: emitted only if status == 8'h00 and cmd bit7 == 1.
    - ADDR: 4 bytes, little-endian, 2-bit counter.
    - DATA: latched data_len bytes; resp_data_idx = byte counter; skipped if data_len == 0.
  - CRC: final CRC byte.
  - Otherwise CMD goes directly to CRC.
- CRC-8:
  - Polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Updated with each written byte from STATUS through the last DATA byte. SOF is excluded.
  - Cleared on acceptance.
- DONE: build_done pulse for one cycle, build_busy falls, then IDLE.
- A new request is accepted no earlier than the cycle after DONE.
- Latency with no backpressure: SOF written the cycle after acceptance; frame length = 4 bytes (no payload) or data_len + 8 bytes (read OK), one per cycle.
- build_req asserted while busy is ignored; it must be held until build_ack.

Optional Feature:
- Macro: FRAME_BUILDER_STALL_ABORT_EN.
- With the macro:
  - A stall counter increments on each emit-state cycle with tx_fifo_full = 1 and clears on every write.
  - On reaching STALL_LIMIT: pulse build_abort, drop the remaining bytes, return to IDLE with no build_done. The partial frame stays in the FIFO, and the host detects it by CRC.
- Without the macro: wait indefinitely on full; build_abort is constant 0; no stall counter is synthesized.

Test Plan:
- Write OK: status 00, cmd 20, FIFO never full -> bytes 5A 00 20 E0 on 4 consecutive cycles after ack; build_done 1 cycle after the E0 write.
- Read OK: status 00, cmd 80, addr 0x1000_0004, len 4, buffer DE AD BE EF -> 5A 00 80 04 00 00 10 DE AD BE EF CRC. CRC matches the software model; resp_data_idx steps 0..3.
- Read error: status 01, cmd 81, len 16 -> exactly 4 bytes 5A 01 81 CRC; no ADDR/DATA bytes.
- Backpressure: tx_fifo_full toggling every cycle during the read-OK frame -> identical byte stream; wr_en never high while full.
- Reset mid-frame: rst low during the DATA byte 2 write -> no further writes, all outputs 0; the next request produces a clean full frame.
- FRAME_BUILDER_STALL_ABORT_EN with STALL_LIMIT = 8: full held high after the STATUS byte -> build_abort pulses after 8 full cycles; no build_done; IDLE accepts the next request.

Source files
------------

// File: rtl/axiuart_frame_builder.sv
// Response-frame serializer: SOF, status, cmd echo, [addr, data], CRC-8, one byte per clock.
// Define FRAME_BUILDER_STALL_ABORT_EN to abort a frame after STALL_LIMIT consecutive full cycles.
module axiuart_frame_builder #(
  parameter int         MAX_DATA_BYTES     = 64,
  parameter logic [7:0] SOF_DEVICE_TO_HOST = 8'h5A,
  parameter int         STALL_LIMIT        = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        build_req,
  output logic        build_ack,
  input  logic [7:0]  status_code,
  input  logic [7:0]  cmd_echo,
  input  logic [31:0] addr,
  input  logic [6:0]  data_len,
  output logic [5:0]  resp_data_idx,
  input  logic [7:0]  resp_data_byte,
  output logic [7:0]  tx_fifo_data,
  output logic        tx_fifo_wr_en,
  input  logic        tx_fifo_full,
  output logic        build_busy,
  output logic        build_done,
  output logic        build_abort
);

  // state  | meaning
  // IDLE   | waiting for build_req; ack and latch inputs
  // SOF    | emit start-of-frame byte
  // STATUS | emit latched status
  // CMD    | emit latched command echo
  // ADDR   | emit address bytes, little-endian (read OK only)
  // DATA   | emit read-data bytes fetched by index (read OK, len > 0)
  // CRC    | emit CRC-8 over STATUS..last DATA
  // DONE   | pulse build_done, return to IDLE
  typedef enum logic [2:0] {IDLE, SOF, STATUS, CMD, ADDR, DATA, CRC, DONE} state_t;

  state_t      state;
  logic [7:0]  status_q;
  logic [7:0]  cmd_q;
  logic [7:0]  crc_q;
  logic [31:0] addr_q;
  logic [6:0]  len_q;
  logic [5:0]  byte_cnt;
  logic [1:0]  addr_cnt;
  logic [7:0]  cur_byte;
  logic        emit;
  logic        wr;
  logic        rd_ok;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  assign emit  = (state != IDLE) && (state != DONE);
  assign rd_ok = (status_q == 8'h00) && cmd_q[7];
  // rst gating keeps every output at zero in any cycle where reset is asserted
  assign wr    = rst && emit && !tx_fifo_full;

  always_comb begin
    cur_byte = 8'h00;
    case (state)
      SOF:     cur_byte = SOF_DEVICE_TO_HOST;
      STATUS:  cur_byte = status_q;
      CMD:     cur_byte = cmd_q;
      ADDR:    cur_byte = addr_q[{addr_cnt, 3'b000} +: 8];
      DATA:    cur_byte = resp_data_byte;
      CRC:     cur_byte = crc_q;
      default: cur_byte = 8'h00;
    endcase
  end

  assign build_ack     = rst && (state == IDLE) && build_req;
  assign build_busy    = rst && emit;
  assign build_done    = rst && (state == DONE);
  assign tx_fifo_wr_en = wr;
  assign tx_fifo_data  = rst ? cur_byte : 8'h00;
  assign resp_data_idx = rst ? byte_cnt : 6'd0;

`ifdef FRAME_BUILDER_STALL_ABORT_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  logic [STALL_W-1:0] stall_cnt;
  logic               abort_q;
  assign build_abort = rst && abort_q;
`else
  assign build_abort = 1'b0 && (STALL_LIMIT > 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      status_q <= 8'h00;
      cmd_q    <= 8'h00;
      addr_q   <= 32'h0;
      len_q    <= 7'd0;
      crc_q    <= 8'h00;
      byte_cnt <= 6'd0;
      addr_cnt <= 2'd0;
`ifdef FRAME_BUILDER_STALL_ABORT_EN
      stall_cnt <= '0;
      abort_q   <= 1'b0;
`endif
    end else begin
`ifdef FRAME_BUILDER_STALL_ABORT_EN
      abort_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (build_req) begin
            status_q <= status_code;
            cmd_q    <= cmd_echo;
            addr_q   <= addr;
            len_q    <= (data_len > 7'(MAX_DATA_BYTES)) ? 7'(MAX_DATA_BYTES) : data_len;
            crc_q    <= 8'h00;
            byte_cnt <= 6'd0;
            addr_cnt <= 2'd0;
`ifdef FRAME_BUILDER_STALL_ABORT_EN
            stall_cnt <= '0;
`endif
            state    <= SOF;
          end
        end
        DONE: state <= IDLE;
        default: begin
          if (wr) begin
`ifdef FRAME_BUILDER_STALL_ABORT_EN
            stall_cnt <= '0;
`endif
            if (state != SOF && state != CRC) crc_q <= crc8_next(crc_q, cur_byte);
            case (state)
              SOF:    state <= STATUS;
              STATUS: state <= CMD;
              CMD:    state <= rd_ok ? ADDR : CRC;
              ADDR: begin
                addr_cnt <= addr_cnt + 2'd1;
                if (addr_cnt == 2'd3) state <= (len_q == 7'd0) ? CRC : DATA;
              end
              DATA: begin
                if ({1'b0, byte_cnt} == len_q - 7'd1) state <= CRC;
                else byte_cnt <= byte_cnt + 6'd1;
              end
              CRC:     state <= DONE;
              default: state <= IDLE;
            endcase
          end
`ifdef FRAME_BUILDER_STALL_ABORT_EN
          else if (stall_cnt == STALL_W'(STALL_LIMIT - 1)) begin
            abort_q <= 1'b1;
            state   <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axiuart_frame_builder.sv
// Randomized bench for axiuart_frame_builder against a queue-based frame model with table CRC-8.
`timescale 1ns/1ps
module tb_axiuart_frame_builder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        build_req = 1'b0;
  logic        build_ack;
  logic [7:0]  status_code = 8'h00;
  logic [7:0]  cmd_echo = 8'h00;
  logic [31:0] addr = 32'h0;
  logic [6:0]  data_len = 7'd0;
  logic [5:0]  resp_data_idx;
  logic [7:0]  resp_data_byte;
  logic [7:0]  tx_fifo_data;
  logic        tx_fifo_wr_en;
  logic        tx_fifo_full = 1'b0;
  logic        build_busy;
  logic        build_done;
  logic        build_abort;

  logic [7:0] buf_mem [64];
  logic [7:0] crc_tbl [256];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int first_wr_cyc, last_wr_cyc, done_cyc;
  int done_cnt = 0;
  int abort_cnt = 0;
  int viol = 0;
  bit done_seen = 0;
  int full_mode = 0;

  assign resp_data_byte = buf_mem[resp_data_idx];

  axiuart_frame_builder #(
    .MAX_DATA_BYTES(64), .SOF_DEVICE_TO_HOST(8'h5A), .STALL_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst), .build_req(build_req), .build_ack(build_ack),
    .status_code(status_code), .cmd_echo(cmd_echo), .addr(addr), .data_len(data_len),
    .resp_data_idx(resp_data_idx), .resp_data_byte(resp_data_byte),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_full(tx_fifo_full),
    .build_busy(build_busy), .build_done(build_done), .build_abort(build_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (tx_fifo_wr_en) begin
      if (tx_fifo_full) viol++;
      if (got_q.size() == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      got_q.push_back(tx_fifo_data);
    end
    if (build_done) begin
      done_seen = 1;
      done_cnt++;
      done_cyc = cyc;
    end
    if (build_abort) abort_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    case (full_mode)
      0:       tx_fifo_full = 1'b0;
      1:       tx_fifo_full = ~tx_fifo_full;
      2:       tx_fifo_full = ($urandom_range(0, 2) == 0);
      default: tx_fifo_full = 1'b1;
    endcase
  endtask

  // remainder of (v * x^8) modulo x^8+x^2+x+1 by long division
  function automatic logic [7:0] tbl_entry(input int v);
    int r;
    r = v << 8;
    for (int b = 15; b >= 8; b--) if (r[b]) r = r ^ (32'h107 << (b - 8));
    return r[7:0];
  endfunction

  task automatic build_expected(input logic [7:0] st, input logic [7:0] cmd,
                                input logic [31:0] a, input int len);
    logic [7:0] crc;
    int n;
    exp_q.delete();
    exp_q.push_back(8'h5A);
    exp_q.push_back(st);
    exp_q.push_back(cmd);
    if (st == 8'h00 && cmd[7]) begin
      n = (len > 64) ? 64 : len;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((a >> (8 * i)) & 32'hFF));
      for (int i = 0; i < n; i++) exp_q.push_back(buf_mem[i]);
    end
    crc = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) crc = crc_tbl[crc ^ exp_q[i]];
    exp_q.push_back(crc);
  endtask

  // leaves time at posedge+1 after the accepting edge, with build_req dropped
  task automatic issue_req(input logic [7:0] st, input logic [7:0] cmd, input logic [31:0] a,
                           input logic [6:0] len, output bit ok, output int ack_cyc);
    got_q.delete();
    done_seen = 0;
    viol = 0;
    ok = 0;
    ack_cyc = 0;
    status_code = st;
    cmd_echo = cmd;
    addr = a;
    data_len = len;
    build_req = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      if (build_ack) begin
        ok = 1;
        ack_cyc = cyc;
      end
      step();
    end
    build_req = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [7:0] st, input logic [7:0] cmd,
                           input logic [31:0] a, input logic [6:0] len, input int mode);
    bit ok;
    int ack_cyc;
    int n;
    build_expected(st, cmd, a, int'(len));
    full_mode = mode;
    issue_req(st, cmd, a, len, ok, ack_cyc);
    check_eq({name, "_ack"}, 32'(ok), 32'd1);
    check_eq({name, "_busy"}, 32'(build_busy), 32'd1);
    n = 0;
    while (!done_seen && n < 3000) begin
      @(negedge clk); #1;
      if (!done_seen) step();
      n++;
    end
    check_eq({name, "_done_seen"}, 32'(done_seen), 32'd1);
    check_eq({name, "_busy_at_done"}, 32'(build_busy), 32'd0);
    check_eq({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_b%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    check_eq({name, "_done_lat"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
    check_eq({name, "_wr_while_full"}, 32'(viol), 32'd0);
    if (mode == 0) begin
      check_eq({name, "_sof_lat"}, 32'(first_wr_cyc), 32'(ack_cyc + 1));
      check_eq({name, "_contig"}, 32'(last_wr_cyc - first_wr_cyc), 32'(exp_q.size() - 1));
    end
    full_mode = 0;
    step();
  endtask

  initial begin
    bit ok;
    int ack_cyc;
    int n;
    int done_before;
    bit hit;

    for (int v = 0; v < 256; v++) crc_tbl[v] = tbl_entry(v);
    for (int i = 0; i < 64; i++) buf_mem[i] = 8'(i);

    build_req = 1'b1;
    repeat (3) step();
    @(negedge clk); #1;
    check_eq("reset_outputs",
             {17'd0, build_ack, tx_fifo_wr_en, build_busy, build_done, build_abort, tx_fifo_data},
             32'd0);
    check_eq("reset_idx", 32'(resp_data_idx), 32'd0);
    build_req = 1'b0;
    step();
    rst = 1'b1;
    step();

    // write OK: 5A 00 20 E0
    run_frame("wr_ok", 8'h00, 8'h20, 32'h0, 7'd0, 0);
    check_eq("wr_ok_crc_const", 32'(got_q.size() == 4 ? got_q[3] : 8'h00), 32'hE0);

    buf_mem[0] = 8'hDE; buf_mem[1] = 8'hAD; buf_mem[2] = 8'hBE; buf_mem[3] = 8'hEF;
    run_frame("rd_ok", 8'h00, 8'h80, 32'h1000_0004, 7'd4, 0);
    run_frame("rd_err", 8'h01, 8'h81, 32'h1000_0004, 7'd16, 0);
    run_frame("rd_bp", 8'h00, 8'h80, 32'h1000_0004, 7'd4, 1);
    run_frame("rd_len0", 8'h00, 8'hC3, 32'hA5A5_0F0F, 7'd0, 0);

    for (int i = 0; i < 64; i++) buf_mem[i] = 8'($urandom);
    run_frame("rd_len64", 8'h00, 8'h80, $urandom, 7'd64, 0);
    run_frame("rd_len100", 8'h00, 8'h80, $urandom, 7'd100, 2);

    for (int k = 0; k < 25; k++) begin
      logic [7:0] st;
      st = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 255));
      for (int i = 0; i < 64; i++) buf_mem[i] = 8'($urandom);
      run_frame($sformatf("rnd%0d", k), st, 8'($urandom), $urandom,
                7'($urandom_range(0, 100)), $urandom_range(0, 2));
    end

    // reset during the write of DATA byte 2
    for (int i = 0; i < 64; i++) buf_mem[i] = 8'($urandom);
    build_expected(8'h00, 8'h80, 32'h1234_5678, 8);
    done_before = done_cnt;
    full_mode = 0;
    issue_req(8'h00, 8'h80, 32'h1234_5678, 7'd8, ok, ack_cyc);
    check_eq("rstmid_ack", 32'(ok), 32'd1);
    hit = 0;
    n = 0;
    while (!hit && n < 40) begin
      #1;
      if (tx_fifo_wr_en && resp_data_idx == 6'd2 && got_q.size() == 9) hit = 1;
      else step();
      n++;
    end
    check_eq("rstmid_reached", 32'(hit), 32'd1);
    rst = 1'b0;
    build_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); #1;
      check_eq($sformatf("rstmid_out%0d", r),
               {17'd0, build_ack, tx_fifo_wr_en, build_busy, build_done, build_abort, tx_fifo_data},
               32'd0);
      check_eq($sformatf("rstmid_idx%0d", r), 32'(resp_data_idx), 32'd0);
    end
    build_req = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) begin @(negedge clk); #1; step(); end
    check_eq("rstmid_wr_count", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < got_q.size(); i++)
      check_eq($sformatf("rstmid_b%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check_eq("rstmid_no_done", 32'(done_cnt), 32'(done_before));
    run_frame("post_rst", 8'h00, 8'h80, 32'hCAFE_F00D, 7'd8, 0);

`ifdef FRAME_BUILDER_STALL_ABORT_EN
    done_before = done_cnt;
    full_mode = 0;
    issue_req(8'h01, 8'h81, 32'h0, 7'd0, ok, ack_cyc);
    check_eq("stall_ack", 32'(ok), 32'd1);
    n = 0;
    while (got_q.size() < 2 && n < 50) begin
      @(negedge clk); #1;
      if (got_q.size() < 2) step();
      n++;
    end
    full_mode = 3;
    step();
    hit = 0;
    n = 0;
    begin
      int full_cycles;
      full_cycles = 0;
      while (!hit && n < 50) begin
        @(negedge clk); #1;
        if (build_abort) hit = 1;
        else begin
          if (build_busy && tx_fifo_full) full_cycles++;
          step();
        end
        n++;
      end
      check_eq("stall_abort_seen", 32'(hit), 32'd1);
      check_eq("stall_full_cycles", 32'(full_cycles), 32'd8);
    end
    check_eq("stall_busy", 32'(build_busy), 32'd0);
    check_eq("stall_bytes", 32'(got_q.size()), 32'd2);
    full_mode = 0;
    step();
    @(negedge clk); #1;
    check_eq("stall_abort_1cyc", 32'(build_abort), 32'd0);
    check_eq("stall_no_done", 32'(done_cnt), 32'(done_before));
    step();
    run_frame("post_abort", 8'h00, 8'h80, 32'h0BAD_BEEF, 7'd3, 0);
`else
    check_eq("abort_never", 32'(abort_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
